cpu_bus_feeder: RTL
===================

CPU_BUS_FEEDER -- requirements
Module: cpu_bus_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: data-word buffer depth, power of two, minimum 2.
REQ-002 SHALL have port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1: one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port Packet_Size, input, 6: run-length packet size; captured when Start is accepted.
REQ-006 SHALL have port Rows_Num, input, 16: number of encoded rows; captured when Start is accepted.
REQ-007 SHALL have port Word_In, input, 32: encoded data word from the host.
REQ-008 SHALL have port Word_Valid, input, 1: Word_In is valid this cycle.
REQ-009 SHALL have port Word_Ready, output, 1: FIFO not full.
REQ-010 SHALL have port Ack, input, 1: decoder's Done_Processing_Current_Packet.
REQ-011 SHALL have port Done_Loading, input, 1: decoder completion.
REQ-012 SHALL have port CPU_Bus, output, 32: word driven to the decoder.
REQ-013 SHALL have port Loading_Enable, output, 1: decoder enable.
REQ-014 SHALL have port Busy, output, 1: the FSM is not in IDLE.
REQ-015 SHALL have port Underrun, output, 1: sticky error, FIFO empty when a pop is required.

Function
REQ-016 SHALL implement FSM states IDLE, HDR_PS, HDR_RN, DATA, FINISH.
REQ-017 IDLE: Start=1 SHALL capture Packet_Size and Rows_Num, clear Underrun, and go to HDR_PS next cycle.
REQ-018 HDR_PS SHALL last exactly 2 cycles: Loading_Enable=1, CPU_Bus={26'b0,Packet_Size}.
REQ-019 HDR_RN SHALL last exactly 1 cycle: Loading_Enable=1, CPU_Bus={16'b0,Rows_Num}; then go to DATA.
REQ-020 On DATA entry, CPU_Bus SHALL show the FIFO head; if the FIFO is empty, CPU_Bus SHALL be 0 and Underrun SHALL set.
REQ-021 In DATA, Loading_Enable SHALL be 1, and CPU_Bus SHALL hold the current word until a pop.
REQ-022 A pop SHALL occur on each 0->1 edge of Ack (registered Ack_d; pop when Ack & ~Ack_d) while in DATA.
REQ-023 Ack held high SHALL cause only one pop.
REQ-024 Ack_d SHALL be 1 on entry to DATA, so Ack already high at entry causes no pop.
REQ-025 A pop SHALL load the next FIFO word onto CPU_Bus in the following cycle (latency 1).
REQ-026 A pop with an empty FIFO SHALL drive CPU_Bus=0 and set Underrun.
REQ-027 Underrun SHALL not stop the FSM.
REQ-028 Push SHALL occur when Word_Valid & Word_Ready, in any state except FINISH.
REQ-029 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-030 Occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Word_Ready SHALL be 0 when occupancy = FIFO_DEPTH, and 0 in FINISH.
REQ-032 Done_Loading=1 in any of HDR_PS, HDR_RN or DATA SHALL go to FINISH next cycle and take priority over a pop.
REQ-033 FINISH SHALL last 1 cycle: Loading_Enable=0, CPU_Bus=0, FIFO flushed (pointers and count to 0); then go to IDLE.
REQ-034 Start outside IDLE SHALL be ignored.
REQ-035 Busy SHALL be 1 in every state except IDLE.
REQ-036 In IDLE, CPU_Bus SHALL be 0 and Loading_Enable 0.
REQ-037 Words pushed in IDLE SHALL be retained for the next transfer.

Reset
REQ-038 RST=0 SHALL immediately force: IDLE; CPU_Bus=0; Loading_Enable=0; Busy=0; Underrun=0; Word_Ready=1; FIFO empty; Ack_d=1; captured registers=0.
REQ-039 Reset mid-transfer SHALL abort with no further pops or pushes, regardless of the CLK phase.
REQ-040 Release SHALL take effect at the first rising CLK edge with RST=1.

Verification
REQ-041 Header timing: push 3 words (A,B,C), then Start with Packet_Size=6, Rows_Num=5 -> CPU_Bus = 0x6, 0x6, 0x5, A on 4 consecutive cycles; Loading_Enable high from cycle 1.
REQ-042 Ack edges: Ack pulses 3 times (1 cycle each) in DATA -> CPU_Bus steps A->B->C->0; Underrun=1 after the third pulse; a fourth pulse keeps CPU_Bus=0.
REQ-043 FIFO full and wrap: push 8 words -> Word_Ready=0; pop 1 and push 1 in the same cycle -> occupancy stays 8; 20 words streamed across the wrap point arrive in order.
REQ-044 Held Ack: Ack=1 held for 5 cycles in DATA -> exactly one pop; Ack=1 at DATA entry -> no pop.
REQ-045 Completion: Done_Loading=1 while 4 words are queued -> FINISH for 1 cycle (Loading_Enable=0, FIFO count=0), then IDLE with Busy=0; Start during FINISH is ignored.
REQ-046 Reset mid-operation: RST=0 asserted between clock edges in DATA -> outputs take their reset values before the next edge; a new Start after release repeats the REQ-041 sequence.

Source files
------------

// File: rtl/cpu_bus_feeder.sv
// Feeds a run-length decoder: a two-word header (packet size, row count) followed by
// buffered data words, each advanced by a rising edge of the decoder's acknowledge.
module cpu_bus_feeder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [5:0]  Packet_Size,
    input  logic [15:0] Rows_Num,
    input  logic [31:0] Word_In,
    input  logic        Word_Valid,
    output logic        Word_Ready,
    input  logic        Ack,
    input  logic        Done_Loading,
    output logic [31:0] CPU_Bus,
    output logic        Loading_Enable,
    output logic        Busy,
    output logic        Underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_PS = 3'd1;
    localparam logic [2:0] S_HDR_RN = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state, state_nx;
    logic          hdr_second;
    logic [5:0]    ps_q;
    logic [15:0]   rn_q;
    logic [31:0]   bus_q;
    logic          ack_d;
    logic          underrun_q;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    logic in_xfer, done_hit, start_acc, ack_rise, pop_req, pop, push, fifo_full, fifo_empty;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign in_xfer    = (state == S_HDR_PS) || (state == S_HDR_RN) || (state == S_DATA);
    assign done_hit   = in_xfer && Done_Loading;
    assign start_acc  = (state == S_IDLE) && Start;
    assign ack_rise   = (state == S_DATA) && Ack && !ack_d;

    // The DATA-entry load consumes the head word exactly like an acknowledged pop.
    assign pop_req = !done_hit && ((state == S_HDR_RN) || ack_rise);
    assign pop     = pop_req && !fifo_empty;
    // A full buffer still accepts a word in the cycle a pop frees a slot.
    assign push    = Word_Valid && (state != S_FINISH) && (!fifo_full || pop);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (Start) state_nx = S_HDR_PS;
            S_HDR_PS: if (Done_Loading) state_nx = S_FINISH;
                      else if (hdr_second) state_nx = S_HDR_RN;
            S_HDR_RN: state_nx = Done_Loading ? S_FINISH : S_DATA;
            S_DATA:   if (Done_Loading) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            hdr_second <= 1'b0;
            ps_q       <= '0;
            rn_q       <= '0;
            bus_q      <= '0;
            ack_d      <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_nx;
            hdr_second <= (state == S_HDR_PS) && !hdr_second;
            // Forced high outside DATA so an Ack already high at entry is not an edge.
            ack_d      <= (state == S_DATA) ? Ack : 1'b1;
            if (start_acc) begin
                ps_q       <= Packet_Size;
                rn_q       <= Rows_Num;
                underrun_q <= 1'b0;
            end
            if (pop_req) begin
                bus_q <= pop ? mem[rptr] : 32'd0;
                if (!pop) underrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (done_hit) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= Word_In;
    end

    always_comb begin
        CPU_Bus = 32'd0;
        case (state)
            S_HDR_PS: CPU_Bus = {26'd0, ps_q};
            S_HDR_RN: CPU_Bus = {16'd0, rn_q};
            S_DATA:   CPU_Bus = bus_q;
            default:  CPU_Bus = 32'd0;
        endcase
    end

    assign Loading_Enable = in_xfer;
    assign Busy           = (state != S_IDLE);
    assign Underrun       = underrun_q;
    assign Word_Ready     = !fifo_full && (state != S_FINISH);

endmodule
